irq_sched: RTL and testbench
============================

# irq_sched

Interrupt scheduler between the timer/counter peripherals (and other interrupt sources) and the CPU core. Collects level-sensitive `interrupt_request` lines, applies a software mask and a fixed priority, and presents one vector at a time to the CPU. It returns a one-cycle `interrupt_executed` pulse to the winning source and holds off further requests until the CPU signals return-from-interrupt. The mask is mapped on the same 8-bit peripheral register bus used by the timer/counters.

## Interface

Parameters:

- `N_SRC`, 8: number of interrupt sources, 1..16. Source 0 has the highest priority.
- `VEC_BASE`, 8'h01: vector number of source 0. Source i presents `VEC_BASE+i`.
- `MASK_ADDR`, 8'h70: address of the mask register, bits [N_SRC-1:0].
- `STAT_ADDR`, 8'h71: address of the read-only status register.

Ports (one clock; reset is asynchronous and active-high):

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `src_req` in N_SRC: level interrupt requests from the sources.
- `src_exec` out N_SRC: one-cycle `interrupt_executed` pulse to the granted source.
- `global_ie` in 1: CPU status-register I bit.
- `cpu_irq` out 1: interrupt request to the CPU.
- `cpu_vector` out 8: vector number, valid while `cpu_irq`=1.
- `cpu_ack` in 1: the CPU takes the vector this cycle.
- `cpu_reti` in 1: the CPU executed return-from-interrupt.
- `addr` in 8, `write` in 1, `read` in 1, `wdata` in 8, `rdata` out 8: register bus.

## Operation

Eligibility and priority:

- `eligible = src_req & mask`.
- The winner is the lowest set index of `eligible`.

Mask register:

- Reset value 0.
- A write at `MASK_ADDR` loads `wdata[N_SRC-1:0]`. Bits at and above `N_SRC` read 0.

Status register, read at `STAT_ADDR`:

- `{state[1:0], 1'b0, idx[4:0]}`.
- `idx` is the latched winner index, 0 when IDLE.

`rdata` is 8'h00 when `read`=0 or when the address does not match.

State machine:

- **IDLE**
  - If `global_ie`=1 and `eligible`≠0: latch the winner index into `idx` and go to REQ.
- **REQ**
  - `cpu_irq`=1 and `cpu_vector`=`VEC_BASE+idx`. Both are held stable while in REQ.
  - `cpu_ack`=1: pulse `src_exec[idx]` for one cycle and go to SVC.
  - Else if `global_ie`=0, or `eligible[idx]`=0 (flag cleared by software, or source masked): go to IDLE with no `src_exec` pulse.
  - A higher-priority request arriving during REQ does not preempt. The latched `idx` stands until ack or withdrawal.
- **SVC**
  - `cpu_irq`=0.
  - `cpu_reti`=1: go to IDLE.
  - Requests are ignored in this state; there is no nesting.

Simultaneous events:

- `cpu_ack` together with `global_ie`=0 in REQ: the ack wins. Pulse and go to SVC.
- `cpu_reti` outside SVC: ignored.
- `cpu_ack` outside REQ: ignored. No pulse.
- A mask write in the same cycle as arbitration: arbitration uses the old mask value.

Reset:

- State IDLE, `idx`=0, mask=0.
- `cpu_irq`=0, `cpu_vector`=8'h00, `src_exec`=0, `rdata`=8'h00 (combinational).
- Reset mid-REQ or mid-SVC drops `cpu_irq` immediately (asynchronous) and produces no `src_exec` pulse.

## Timing

- All outputs except `rdata` are registered.
- A request edge at cycle n (with `global_ie`=1 and the mask bit set) gives `cpu_irq`=1 at n+1.
- `cpu_ack` at cycle n gives `src_exec[idx]`=1 during n+1 only, `cpu_irq`=0 at n+1, and state SVC.
  - The source clears its own flag on `src_exec`; its request line may therefore stay high for about one more cycle.
  - After reti, re-arbitration is delayed by at least one IDLE cycle, so a stale level cannot re-fire.
- `cpu_reti` at cycle n gives IDLE at n+1. The earliest next `cpu_irq` is at n+2.
- The register bus has zero-wait writes that take effect at the next clock edge. Reads are combinational.

## Structure

Shared package `irq_pkg` holds:

- `typedef enum logic [1:0] {IDLE=0, REQ=1, SVC=2} irq_state_t`.
- Default `MASK_ADDR`/`STAT_ADDR` constants, kept alongside the timer/counter address constants.

Sub-module `irq_prio_enc`:

- Parameter `N`.
- Input `N` bits, outputs `valid` and `index[4:0]` (lowest set bit).
- Purely combinational.

## Test plan

1. Reset, write mask=8'hFF, `global_ie`=1, raise `src_req[3]` at cycle 10 -> `cpu_irq`=1 at 11 with `cpu_vector`=8'h04. `cpu_ack` at 13 -> `src_exec`=8'h08 during 14 only. STAT reads {SVC,idx=3}=8'h83.
2. `src_req`=8'b0010_0100 together -> vector 8'h03 (idx 2). After ack and reti, with `src_req[2]` dropped -> next vector 8'h06 at reti+2.
3. In REQ with idx=5, raise `src_req[1]` -> `cpu_vector` stays 8'h06 until ack. After reti -> vector 8'h02.
4. In REQ, drop `global_ie` for one cycle with no ack -> `cpu_irq`=0 next cycle, no `src_exec` pulse. Restore `global_ie` -> `cpu_irq` returns 2 cycles later.
5. Mask=8'h00 with `src_req`=8'hFF -> `cpu_irq` stays 0 for 100 cycles. Write mask=8'h80 -> vector 8'h08 at write+2.
6. Assert `rst` mid-SVC and mid-REQ -> `cpu_irq`, `src_exec` and mask are 0 in the same cycle. After release, a request with mask 0 does not fire.

Source files
------------

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the interrupt scheduler and its neighbours on the
// 8-bit peripheral register bus.
//   - irq_state_t   : scheduler state encoding, also visible in the status reg
//   - *_ADDR        : default register addresses on the peripheral bus
//   - irq_stat_byte : packs the status register byte
// -----------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_t;

  // Timer/counter block addresses share this map with the scheduler.
  localparam logic [7:0] TC0_BASE_ADDR = 8'h60;
  localparam logic [7:0] TC1_BASE_ADDR = 8'h68;

  // Interrupt scheduler defaults.
  localparam logic [7:0] IRQ_MASK_ADDR = 8'h70;
  localparam logic [7:0] IRQ_STAT_ADDR = 8'h71;

  // Status byte layout: {state[1:0], 1'b0, idx[4:0]}.
  function automatic logic [7:0] irq_stat_byte(input irq_state_t st,
                                               input logic [4:0] idx);
    return {st, 1'b0, idx};
  endfunction

endpackage

// File: rtl/irq_sched_if.sv
// -----------------------------------------------------------------------------
// irq_sched_if
// CPU handshake plus peripheral register bus seen by the interrupt scheduler.
//   global_ie  : CPU I bit                 (master -> slave)
//   cpu_ack    : CPU takes the vector      (master -> slave)
//   cpu_reti   : return-from-interrupt     (master -> slave)
//   cpu_irq    : interrupt request         (slave  -> master)
//   cpu_vector : vector, valid with irq    (slave  -> master)
//   addr/write/read/wdata : register bus   (master -> slave)
//   rdata      : combinational read data   (slave  -> master)
// -----------------------------------------------------------------------------
interface irq_sched_if;
  logic       global_ie;
  logic       cpu_ack;
  logic       cpu_reti;
  logic       cpu_irq;
  logic [7:0] cpu_vector;
  logic [7:0] addr;
  logic       write;
  logic       read;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (
    output global_ie, cpu_ack, cpu_reti, addr, write, read, wdata,
    input  cpu_irq, cpu_vector, rdata
  );

  modport slave (
    input  global_ie, cpu_ack, cpu_reti, addr, write, read, wdata,
    output cpu_irq, cpu_vector, rdata
  );
endinterface

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: reports the lowest set bit of i_req.
//   i_req   : request vector, bit 0 has the highest priority
//   o_valid : at least one bit set
//   o_index : index of the lowest set bit (0 when none)
// Purely combinational.
// -----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_index
);

  // Scan from the top down so the lowest set bit is the last one to land.
  always_comb begin
    o_valid = |i_req;
    o_index = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      o_index = i_req[i] ? 5'(i) : o_index;
    end
  end

endmodule

// File: rtl/irq_sched.sv
// -----------------------------------------------------------------------------
// irq_sched
// Interrupt scheduler between level-sensitive interrupt sources and the CPU.
// Masks requests, picks the highest-priority one (lowest index), presents its
// vector, pulses the source's executed line on ack and waits for reti before
// arbitrating again.
//   clk, rst    : clock, asynchronous active-high reset
//   i_src_req   : level requests from the sources
//   o_src_exec  : one-cycle executed pulse to the granted source
//   bus         : CPU handshake and register bus (slave side)
// -----------------------------------------------------------------------------
module irq_sched
  import irq_pkg::*;
#(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] VEC_BASE  = 8'h01,
  parameter logic [7:0] MASK_ADDR = IRQ_MASK_ADDR,
  parameter logic [7:0] STAT_ADDR = IRQ_STAT_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_src_req,
  output logic [N_SRC-1:0] o_src_exec,
  irq_sched_if.slave       bus
);

  irq_state_t       r_state;
  irq_state_t       w_state_nxt;
  logic [4:0]       r_idx;
  logic [4:0]       w_idx_nxt;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] w_mask_load;
  logic             w_mask_wr;
  logic             r_irq;
  logic             w_irq_nxt;
  logic [7:0]       r_vector;
  logic [7:0]       w_vector_nxt;
  logic [N_SRC-1:0] r_exec;
  logic [N_SRC-1:0] w_exec_nxt;

  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_idx_onehot;
  logic             w_idx_elig;
  logic             w_win_valid;
  logic [4:0]       w_win_idx;
  logic [7:0]       w_rdata;

  // Arbitration always sees the mask as it was before this cycle's write.
  assign w_eligible  = i_src_req & r_mask;
  assign w_mask_wr   = bus.write && (bus.addr == MASK_ADDR);
  assign w_mask_load = N_SRC'(bus.wdata);

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .i_req   (w_eligible),
    .o_valid (w_win_valid),
    .o_index (w_win_idx)
  );

  // One-hot of the latched winner; used for the exec pulse and withdrawal test.
  always_comb begin
    w_idx_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_idx_onehot[i] = (r_idx == 5'(i));
    end
    w_idx_elig = |(w_idx_onehot & w_eligible);
  end

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_irq_nxt    = 1'b0;
    w_vector_nxt = 8'h00;
    w_exec_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (bus.global_ie && w_win_valid) begin
          w_state_nxt  = REQ;
          w_idx_nxt    = w_win_idx;
          w_irq_nxt    = 1'b1;
          w_vector_nxt = VEC_BASE + {3'b000, w_win_idx};
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      REQ: begin
        // Ack beats a simultaneous drop of global_ie or withdrawal.
        if (bus.cpu_ack) begin
          w_state_nxt = SVC;
          w_exec_nxt  = w_idx_onehot;
        end else if (!bus.global_ie || !w_idx_elig) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 5'd0;
        end else begin
          w_irq_nxt    = 1'b1;
          w_vector_nxt = r_vector;
        end
      end
      SVC: begin
        if (bus.cpu_reti) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 5'd0;
        end else begin
          w_state_nxt = SVC;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = 5'd0;
      end
    endcase
  end

  // State, latched index, mask and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= 5'd0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
      r_vector <= 8'h00;
      r_exec   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_irq    <= w_irq_nxt;
      r_vector <= w_vector_nxt;
      r_exec   <= w_exec_nxt;
      if (w_mask_wr) begin
        r_mask <= w_mask_load;
      end
    end
  end

  // Combinational register read mux.
  always_comb begin
    w_rdata = 8'h00;
    if (bus.read && (bus.addr == MASK_ADDR)) begin
      w_rdata = 8'(r_mask);
    end else if (bus.read && (bus.addr == STAT_ADDR)) begin
      w_rdata = irq_stat_byte(r_state, r_idx);
    end else begin
      w_rdata = 8'h00;
    end
  end

  assign bus.cpu_irq    = r_irq;
  assign bus.cpu_vector = r_vector;
  assign bus.rdata      = w_rdata;
  assign o_src_exec     = r_exec;

endmodule

// File: tb/tb_irq_sched.sv
// -----------------------------------------------------------------------------
// tb_irq_sched
// Directed scenarios plus a randomized run against a behavioural model of the
// interrupt scheduler.
// -----------------------------------------------------------------------------
module tb_irq_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] src_req;
  logic [7:0] src_exec;
  int         n_checks = 0;
  int         n_fail   = 0;

  irq_sched_if bus_if ();

  irq_sched #(
    .N_SRC     (8),
    .VEC_BASE  (8'h01),
    .MASK_ADDR (8'h70),
    .STAT_ADDR (8'h71)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_src_req  (src_req),
    .o_src_exec (src_exec),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.write = 1'b1;
    tick();
    bus_if.write = 1'b0;
    bus_if.addr  = 8'h00;
  endtask

  task automatic pulse_ack;
    bus_if.cpu_ack = 1'b1;
    tick();
    bus_if.cpu_ack = 1'b0;
  endtask

  task automatic pulse_reti;
    bus_if.cpu_reti = 1'b1;
    tick();
    bus_if.cpu_reti = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] rd;
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector, src_exec, bus_if.rdata} !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq=%b vec=%h exec=%h rdata=%h required all zero",
               bus_if.cpu_irq, bus_if.cpu_vector, src_exec, bus_if.rdata);
    end
    rst = 1'b0;
    tick();
    bus_if.read = 1'b1;
    bus_if.addr = 8'h71;
    #1 rd = bus_if.rdata;
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_stat: got %h required 00", rd);
    end
    bus_if.addr = 8'h70;
    #1 rd = bus_if.rdata;
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mask: got %h required 00", rd);
    end
    bus_if.read = 1'b0;
    bus_if.addr = 8'h00;
  endtask

  task automatic test_basic;
    logic [7:0] rd;
    bus_if.global_ie = 1'b1;
    write_reg(8'h70, 8'hFF);
    src_req = 8'h08;
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector, src_exec} !== {1'b1, 8'h04, 8'h00}) begin
      n_fail++;
      $display("FAIL basic_req: irq=%b vec=%h exec=%h required 1/04/00",
               bus_if.cpu_irq, bus_if.cpu_vector, src_exec);
    end
    tick();
    pulse_ack();
    src_req = 8'h00;
    n_checks++;
    if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h08}) begin
      n_fail++;
      $display("FAIL basic_exec: irq=%b exec=%h required 0/08", bus_if.cpu_irq, src_exec);
    end
    bus_if.read = 1'b1;
    bus_if.addr = 8'h71;
    #1 rd = bus_if.rdata;
    n_checks++;
    if (rd !== 8'h83) begin
      n_fail++;
      $display("FAIL basic_stat_svc: got %h required 83", rd);
    end
    bus_if.read = 1'b0;
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL basic_exec_once: irq=%b exec=%h required 0/00", bus_if.cpu_irq, src_exec);
    end
    pulse_reti();
    bus_if.read = 1'b1;
    bus_if.addr = 8'h71;
    #1 rd = bus_if.rdata;
    n_checks++;
    if (rd !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_stat_idle: got %h required 00", rd);
    end
    bus_if.read = 1'b0;
    bus_if.addr = 8'h00;
  endtask

  task automatic test_priority;
    src_req = 8'b0010_0100;
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h03}) begin
      n_fail++;
      $display("FAIL prio_pair: irq=%b vec=%h required 1/03", bus_if.cpu_irq, bus_if.cpu_vector);
    end
    pulse_ack();
    src_req = 8'b0010_0000;
    n_checks++;
    if (src_exec !== 8'h04) begin
      n_fail++;
      $display("FAIL prio_exec2: got %h required 04", src_exec);
    end
    tick();
    n_checks++;
    if (bus_if.cpu_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_svc_ignores: irq=%b required 0", bus_if.cpu_irq);
    end
    pulse_reti();
    n_checks++;
    if (bus_if.cpu_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_reti_plus1: irq=%b required 0", bus_if.cpu_irq);
    end
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h06}) begin
      n_fail++;
      $display("FAIL prio_reti_plus2: irq=%b vec=%h required 1/06", bus_if.cpu_irq, bus_if.cpu_vector);
    end
  endtask

  task automatic test_no_preempt;
    src_req = 8'b0010_0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h06}) begin
        n_fail++;
        $display("FAIL nopreempt_hold[%0d]: irq=%b vec=%h required 1/06",
                 k, bus_if.cpu_irq, bus_if.cpu_vector);
      end
    end
    pulse_ack();
    src_req = 8'b0000_0010;
    n_checks++;
    if (src_exec !== 8'h20) begin
      n_fail++;
      $display("FAIL nopreempt_exec5: got %h required 20", src_exec);
    end
    pulse_reti();
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h02}) begin
      n_fail++;
      $display("FAIL nopreempt_next: irq=%b vec=%h required 1/02", bus_if.cpu_irq, bus_if.cpu_vector);
    end
    pulse_ack();
    src_req = 8'h00;
    n_checks++;
    if (src_exec !== 8'h02) begin
      n_fail++;
      $display("FAIL nopreempt_exec1: got %h required 02", src_exec);
    end
    pulse_reti();
  endtask

  task automatic test_ie_drop;
    src_req = 8'h01;
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL iedrop_req: irq=%b vec=%h required 1/01", bus_if.cpu_irq, bus_if.cpu_vector);
    end
    bus_if.global_ie = 1'b0;
    tick();
    bus_if.global_ie = 1'b1;
    n_checks++;
    if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL iedrop_withdraw: irq=%b exec=%h required 0/00", bus_if.cpu_irq, src_exec);
    end
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector, src_exec} !== {1'b1, 8'h01, 8'h00}) begin
      n_fail++;
      $display("FAIL iedrop_return: irq=%b vec=%h exec=%h required 1/01/00",
               bus_if.cpu_irq, bus_if.cpu_vector, src_exec);
    end
    src_req = 8'h00;
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL iedrop_srcgone: irq=%b exec=%h required 0/00", bus_if.cpu_irq, src_exec);
    end
  endtask

  task automatic test_mask;
    int bad;
    write_reg(8'h70, 8'h00);
    src_req = 8'hFF;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      n_checks++;
      if (bus_if.cpu_irq !== 1'b0) begin
        n_fail++;
        bad++;
        if (bad < 4) $display("FAIL mask_zero_quiet[%0d]: irq=%b required 0", k, bus_if.cpu_irq);
      end
    end
    write_reg(8'h70, 8'h80);
    n_checks++;
    if (bus_if.cpu_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_write_old: irq=%b required 0 at write+1", bus_if.cpu_irq);
    end
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h08}) begin
      n_fail++;
      $display("FAIL mask_write_new: irq=%b vec=%h required 1/08", bus_if.cpu_irq, bus_if.cpu_vector);
    end
    pulse_ack();
    src_req = 8'h00;
    n_checks++;
    if (src_exec !== 8'h80) begin
      n_fail++;
      $display("FAIL mask_exec7: got %h required 80", src_exec);
    end
    pulse_reti();
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd;
    write_reg(8'h70, 8'hFF);
    src_req = 8'h01;
    tick();
    pulse_ack();
    // now in service
    rst = 1'b1;
    #1;
    bus_if.read = 1'b1;
    bus_if.addr = 8'h70;
    #1 rd = bus_if.rdata;
    bus_if.read = 1'b0;
    n_checks++;
    if ({bus_if.cpu_irq, src_exec, rd} !== {1'b0, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_svc: irq=%b exec=%h mask=%h required 0/00/00",
               bus_if.cpu_irq, src_exec, rd);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (bus_if.cpu_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mask_cleared[%0d]: irq=%b required 0", k, bus_if.cpu_irq);
      end
    end
    write_reg(8'h70, 8'hFF);
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, bus_if.cpu_vector} !== {1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL rst_rearm: irq=%b vec=%h required 1/01", bus_if.cpu_irq, bus_if.cpu_vector);
    end
    bus_if.cpu_ack = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_req_immediate: irq=%b exec=%h required 0/00", bus_if.cpu_irq, src_exec);
    end
    tick();
    n_checks++;
    if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_req_nopulse: irq=%b exec=%h required 0/00", bus_if.cpu_irq, src_exec);
    end
    bus_if.cpu_ack = 1'b0;
    rst = 1'b0;
    src_req = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if ({bus_if.cpu_irq, src_exec} !== {1'b0, 8'h00}) begin
        n_fail++;
        $display("FAIL rst_after_release[%0d]: irq=%b exec=%h required 0/00",
                 k, bus_if.cpu_irq, src_exec);
      end
    end
    src_req = 8'h00;
  endtask

  // Randomized run against a behavioural model built from the scheduling rules.
  task automatic test_random;
    bit         m_pres;
    bit         m_serv;
    int         m_idx;
    logic [7:0] m_mask;
    logic [7:0] elig;
    logic [7:0] e_exec;
    logic [7:0] e_rd;
    logic [1:0] phase;
    int         low;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pres = 1'b0;
    m_serv = 1'b0;
    m_idx  = 0;
    m_mask = 8'h00;
    for (int c = 0; c < 600; c++) begin
      src_req          = 8'($urandom) & 8'($urandom);
      bus_if.global_ie = ($urandom_range(0, 7) != 0);
      bus_if.cpu_ack   = ($urandom_range(0, 3) == 0);
      bus_if.cpu_reti  = ($urandom_range(0, 3) == 0);
      bus_if.write     = ($urandom_range(0, 7) == 0);
      bus_if.read      = ($urandom_range(0, 1) == 0);
      case ($urandom_range(0, 2))
        0:       bus_if.addr = 8'h70;
        1:       bus_if.addr = 8'h71;
        default: bus_if.addr = 8'($urandom);
      endcase
      bus_if.wdata = 8'($urandom);
      #1;
      phase = m_serv ? 2'd2 : (m_pres ? 2'd1 : 2'd0);
      if (!bus_if.read)              e_rd = 8'h00;
      else if (bus_if.addr == 8'h70) e_rd = m_mask;
      else if (bus_if.addr == 8'h71) e_rd = {phase, 1'b0, 5'(m_idx)};
      else                           e_rd = 8'h00;
      n_checks++;
      if (bus_if.rdata !== e_rd) begin
        n_fail++;
        $display("FAIL rand_rdata[%0d]: addr=%h got %h required %h", c, bus_if.addr, bus_if.rdata, e_rd);
      end
      elig   = src_req & m_mask;
      e_exec = 8'h00;
      if (m_pres) begin
        if (bus_if.cpu_ack) begin
          e_exec = 8'h01 << m_idx;
          m_pres = 1'b0;
          m_serv = 1'b1;
        end else if (!bus_if.global_ie || !elig[m_idx]) begin
          m_pres = 1'b0;
          m_idx  = 0;
        end
      end else if (m_serv) begin
        if (bus_if.cpu_reti) begin
          m_serv = 1'b0;
          m_idx  = 0;
        end
      end else if (bus_if.global_ie && elig != 8'h00) begin
        low = 0;
        for (int i = 7; i >= 0; i--) if (elig[i]) low = i;
        m_idx  = low;
        m_pres = 1'b1;
      end
      if (bus_if.write && bus_if.addr == 8'h70) m_mask = bus_if.wdata;
      tick();
      n_checks++;
      if ({bus_if.cpu_irq, src_exec} !== {m_pres, e_exec}) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: irq=%b exec=%h required %b/%h",
                 c, bus_if.cpu_irq, src_exec, m_pres, e_exec);
      end
      if (m_pres) begin
        n_checks++;
        if (bus_if.cpu_vector !== 8'(8'h01 + m_idx)) begin
          n_fail++;
          $display("FAIL rand_vec[%0d]: got %h required %h", c, bus_if.cpu_vector, 8'(8'h01 + m_idx));
        end
      end
    end
    bus_if.write    = 1'b0;
    bus_if.read     = 1'b0;
    bus_if.cpu_ack  = 1'b0;
    bus_if.cpu_reti = 1'b0;
    src_req         = 8'h00;
  endtask

  initial begin
    rst              = 1'b1;
    src_req          = 8'h00;
    bus_if.global_ie = 1'b0;
    bus_if.cpu_ack   = 1'b0;
    bus_if.cpu_reti  = 1'b0;
    bus_if.addr      = 8'h00;
    bus_if.write     = 1'b0;
    bus_if.read      = 1'b0;
    bus_if.wdata     = 8'h00;
    tick();
    test_reset();
    test_basic();
    test_priority();
    test_no_preempt();
    test_ie_drop();
    test_mask();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
